// File: rtl/alu_pkg.sv
// Shared encodings, FSM states and control decode for the bit-serial ALU.
// SERIAL_ALU_NOR_EN: when defined, alu_ctl 1100 decodes to NOR; otherwise it is illegal.
package alu_pkg;

  localparam logic [3:0] CTL_AND = 4'b0000;
  localparam logic [3:0] CTL_OR  = 4'b0001;
  localparam logic [3:0] CTL_ADD = 4'b0010;
  localparam logic [3:0] CTL_SUB = 4'b0110;
  localparam logic [3:0] CTL_SLT = 4'b0111;
  localparam logic [3:0] CTL_NOR = 4'b1100;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_LESS = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_e;

  typedef struct packed {
    logic [1:0] op;
    logic       b_inv;
    logic       arith;
    logic       slt;
    logic       illegal;
  } ctl_t;

  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

  // a_invert is decoded separately by the sequencer so it vanishes when NOR is disabled
  function automatic ctl_t decode_ctl(input logic [3:0] ctl);
    ctl_t d;
    d = '{op: OP_AND, b_inv: 1'b0, arith: 1'b0, slt: 1'b0, illegal: 1'b0};
    case (ctl)
      CTL_AND: d.op = OP_AND;
      CTL_OR:  d.op = OP_OR;
      CTL_ADD: begin
        d.op    = OP_ADD;
        d.arith = 1'b1;
      end
      CTL_SUB: begin
        d.op    = OP_ADD;
        d.b_inv = 1'b1;
        d.arith = 1'b1;
      end
      CTL_SLT: begin
        d.op    = OP_LESS;
        d.b_inv = 1'b1;
        d.arith = 1'b1;
        d.slt   = 1'b1;
      end
`ifdef SERIAL_ALU_NOR_EN
      CTL_NOR: begin
        d.op    = OP_AND;
        d.b_inv = 1'b1;
      end
`endif
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// Combinational 1-bit ALU slice: invertible operands, full adder, AND/OR/ADD/LESS select,
// plus the set (sum) and overflow (carry_in ^ carry_out) taps used at the MSB.
module alu_bit_slice
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       a_invert,
  input  logic       b_invert,
  input  logic       carry_in,
  input  logic       less,
  input  logic [1:0] operation,
  output logic       result,
  output logic       carry_out,
  output logic       set,
  output logic       overflow
);

  logic aa;
  logic bb;
  logic sum;

  always_comb begin
    aa        = a ^ a_invert;
    bb        = b ^ b_invert;
    sum       = aa ^ bb ^ carry_in;
    carry_out = (aa & bb) | (aa & carry_in) | (bb & carry_in);
    set       = sum;
    overflow  = carry_in ^ carry_out;
    case (operation)
      OP_AND:  result = aa & bb;
      OP_OR:   result = aa | bb;
      OP_ADD:  result = sum;
      default: result = less;
    endcase
  end

endmodule

// File: rtl/serial_alu.sv
// Bit-serial WIDTH-bit ALU sequencer driving one alu_bit_slice LSB-first, one bit per clock.
// SERIAL_ALU_NOR_EN: when defined, alu_ctl 1100 performs NOR (adds the a_invert register).
module serial_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       alu_ctl,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-2:0] res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  ctl_t             ctl_q, ctl_d;
  logic             set_q, set_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             overflow_q, overflow_d;

  logic             a_inv;
  logic             s_res;
  logic             s_cout;
  logic             s_set;
  logic             s_ovf;
  logic [WIDTH-1:0] res_full;

  alu_bit_slice u_slice (
    .a         (a_q[0]),
    .b         (b_q[0]),
    .a_invert  (a_inv),
    .b_invert  (ctl_q.b_inv),
    .carry_in  (carry_q),
    .less      (1'b0),
    .operation (ctl_q.op),
    .result    (s_res),
    .carry_out (s_cout),
    .set       (s_set),
    .overflow  (s_ovf)
  );

`ifdef SERIAL_ALU_NOR_EN
  logic a_inv_q, a_inv_d;

  always_comb begin
    a_inv_d = a_inv_q;
    if (state_q == IDLE && start) a_inv_d = (alu_ctl == CTL_NOR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) a_inv_q <= 1'b0;
    else        a_inv_q <= a_inv_d;
  end

  assign a_inv = a_inv_q;
`else
  assign a_inv = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    cnt_d      = cnt_q;
    carry_d    = carry_q;
    ctl_d      = ctl_q;
    set_d      = set_q;
    ovf_d      = ovf_q;
    result_d   = result_q;
    zero_d     = zero_q;
    overflow_d = overflow_q;
    // the incoming slice bit enters at the MSB; after WIDTH shifts this is the whole word
    res_full   = {s_res, res_q};

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_d     = src_a;
          b_d     = src_b;
          ctl_d   = decode_ctl(alu_ctl);
          cnt_d   = '0;
          carry_d = ctl_d.b_inv;
          res_d   = '0;
        end
      end
      RUN: begin
        carry_d = s_cout;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        res_d   = res_full[WIDTH-1:1];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          set_d = s_set;
          ovf_d = ctl_q.arith & s_ovf;
          if (ctl_q.slt) begin
            state_d = FIX;
          end else begin
            state_d    = DONE;
            result_d   = ctl_q.illegal ? '0 : res_full;
            zero_d     = (result_d == '0);
            overflow_d = ctl_q.arith & s_ovf;
          end
        end
      end
      FIX: begin
        state_d    = DONE;
        result_d   = {{(WIDTH-1){1'b0}}, set_q};
        zero_d     = ~set_q;
        overflow_d = ovf_q;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      ctl_q      <= '0;
      set_q      <= 1'b0;
      ovf_q      <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      res_q      <= res_d;
      cnt_q      <= cnt_d;
      carry_q    <= carry_d;
      ctl_q      <= ctl_d;
      set_q      <= set_d;
      ovf_q      <= ovf_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = (state_q == RUN) || (state_q == FIX);
  assign done     = (state_q == DONE);
  assign result   = result_q;
  assign zero     = zero_q;
  assign overflow = overflow_q;

endmodule
